serial_adder: RTL and testbench

- Bit-serial N-bit adder built around the existing 1-bit full_adder cell.
- Parallel-loads two operands and a carry-in, then feeds one bit pair per clock, LSB first, into a single full_adder instance (ports A, B, Cin, S, Cout).
- Holds the carry between bits in a flip-flop and reassembles the sum.
- Sits directly upstream of full_adder, sequencing it; it is the first sequential consumer of the cell in the adder library.

---
 rtl/serial_adder.sv | 145 ++++++++++++++
 tb/tb_serial_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: sequences one full_adder cell over WIDTH clock cycles,
// LSB first, keeping the inter-bit carry in a flop and shifting the sum bits
// into a result register that is published to sum/cout once per operation.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one bit pair per clock through the full_adder, busy=1
// DONE  | one-cycle done pulse, returns to IDLE unconditionally
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_s;
    logic fa_cout;

    full_adder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state and datapath: load on accept, shift/accumulate in RUN,
    // publish the assembled result on the last RUN edge.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and all registered outputs; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked every cycle against an
// arithmetic model, plus a WIDTH=4 instance swept exhaustively.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n8 = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       rst_n4 = 1'b0;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt8 = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase = edges since the accepting edge, -1 when idle.
    int       phase = -1;
    logic [8:0] pend = '0;
    logic [7:0] e_sum = '0;
    logic       e_cout = 1'b0;

    always @(posedge clk or negedge rst_n8) begin
        if (!rst_n8) begin
            phase  = -1;
            e_sum  = '0;
            e_cout = 1'b0;
        end else if (phase == -1) begin
            if (start8 === 1'b1) begin
                phase = 0;
                pend  = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
            end
        end else if (phase == 8) begin
            phase = -1;
        end else begin
            phase++;
            if (phase == 8) begin
                e_sum  = pend[7:0];
                e_cout = pend[8];
            end
        end
    end

    always @(negedge clk) begin
        chk("busy8", busy8, (phase >= 0 && phase < 8) ? 1 : 0);
        chk("done8", done8, (phase == 8) ? 1 : 0);
        chk("sum8", sum8, e_sum);
        chk("cout8", cout8, e_cout);
        if (done8 === 1'b1) done_cnt8++;
    end

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string nm,
                        input bit pulse_mid);
        int n, nbusy, d0;
        bit seen;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        d0 = done_cnt8; n = 0; nbusy = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (busy8 === 1'b1) nbusy++;
            if (pulse_mid && n == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end
            if (pulse_mid && n == 4) start8 = 1'b0;
            if (done8 === 1'b1) seen = 1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 1);
        chk({nm, "_latency"}, n, 9);
        chk({nm, "_busy_cycles"}, nbusy, 8);
        chk({nm, "_sum"}, sum8, es);
        chk({nm, "_cout"}, cout8, ec);
        repeat (3) @(negedge clk);
        chk({nm, "_done_count"}, done_cnt8 - d0, 1);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        #21;
        rst_n8 = 1'b1;
        rst_n4 = 1'b1;

        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero", 0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01", 0);
        run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_c", 0);
        run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "3c_42", 0);
        run8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, "ignore_start", 1);

        // Asynchronous reset in the middle of RUN.
        begin
            int d0;
            @(posedge clk); #1;
            start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
            @(posedge clk); #1;
            start8 = 1'b0;
            d0 = done_cnt8;
            repeat (4) @(posedge clk);
            #2 rst_n8 = 1'b0;
            #1;
            chk("midrst_busy", busy8, 0);
            chk("midrst_done", done8, 0);
            chk("midrst_sum", sum8, 0);
            chk("midrst_cout", cout8, 0);
            repeat (2) @(posedge clk);
            #3 rst_n8 = 1'b1;
            repeat (12) @(negedge clk);
            chk("midrst_no_done", done_cnt8 - d0, 0);
        end
        run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_rst", 0);

        // start held high: back-to-back operations.
        begin
            int last, ndone;
            last = -1; ndone = 0;
            @(posedge clk); #1;
            start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done8 === 1'b1) begin
                    if (last < 0) chk("held_first_sum", sum8, 8'h30);
                    else chk("held_interval", i - last, 10);
                    last = i;
                    ndone++;
                end
                @(posedge clk); #1;
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            start8 = 1'b0;
            chk("held_done_count", ndone, 4);
            repeat (12) @(negedge clk);
        end

        // WIDTH=4 exhaustive sweep.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int n;
                    @(posedge clk); #1;
                    start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
                    @(posedge clk); #1;
                    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                    n = 0;
                    while (done4 !== 1'b1 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("add4", {cout4, sum4}, 32'(ai + bi + ci));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
